mac_rx: RTL

- RMII receive MAC, the counterpart of the team's RMII transmit MAC. It accepts frames that MAC builds: preamble/SFD, dst MAC, src MAC, 16'h5139 magic, 16-bit sequence, 32-bit payload words, FCS.
- Deserialises dibits into 32-bit words and filters on destination MAC and magic.
- Checks the CRC32 and writes payload words into a downstream FIFO that supports commit/rewind.
- Per frame, emits exactly one commit (with word count and sequence number) or one discard.

---
 rtl/mac_pkg.sv | 42 ++++
 rtl/mac_rx_crc32.sv | 34 +++
 rtl/mac_rx.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants for the RMII MAC: frame magic, CRC32 parameters,
// discard reason codes, receive FSM state encoding and the CRC step function.
package mac_pkg;

  localparam logic [15:0] ETHER_MAGIC = 16'h5139;
  localparam logic [31:0] CRC_POLY    = 32'hedb88320;
  localparam logic [31:0] CRC_INIT    = 32'hffffffff;
  localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;

  localparam logic [1:0] DIBIT_PRE = 2'b01;
  localparam logic [1:0] DIBIT_SFD = 2'b11;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_DST   = 3'd1;
  localparam logic [2:0] ERR_MAGIC = 3'd2;
  localparam logic [2:0] ERR_ALIGN = 3'd3;
  localparam logic [2:0] ERR_RUNT  = 3'd4;
  localparam logic [2:0] ERR_CRC   = 3'd5;
  localparam logic [2:0] ERR_OVF   = 3'd6;
  localparam logic [2:0] ERR_FULL  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HEADER   = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_DROP     = 3'd4
  } state_e;

  // Reflected CRC32 advanced by one dibit, bit 0 first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc,
                                              input logic [1:0]  dibit);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ dibit[i]) c = (c >> 1) ^ CRC_POLY;
      else                 c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_rx_crc32.sv
// Dibit-serial reflected CRC32 register with residue match flag.
// Shared between the RMII receive and transmit MACs.
module mac_rx_crc32
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc,
  output logic        match
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next CRC: reload on init, otherwise fold in one dibit when enabled.
  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = CRC_INIT;
    else if (en) crc_d = crc32_dibit(crc_q, dibit);
  end

  // CRC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else        crc_q <= crc_d;
  end

  assign crc   = crc_q;
  assign match = (crc_q == CRC_RESIDUE);

endmodule

// File: rtl/mac_rx.sv
// RMII receive MAC: preamble/SFD hunt, header filtering (dst MAC, magic),
// 32-bit payload deserialisation with one-word holdback so the FCS is never
// written, CRC32 check and a single commit or discard pulse per frame.
// Optional build macro MAC_RX_STATS_EN adds saturating good/bad frame counters.
module mac_rx
  import mac_pkg::*;
#(
  parameter int MAC_PACKET_BITS = 9,
  parameter int MAX_WORDS       = 375,
  parameter int MIN_PREAMBLE    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx0,
  input  logic                       rx1,
  input  logic                       crs_dv,
  input  logic [47:0]                local_mac,
  output logic [31:0]                data_out,
  output logic                       data_wr_en,
  input  logic                       data_full,
  output logic                       frame_commit,
  output logic                       frame_discard,
  output logic [MAC_PACKET_BITS-1:0] frame_len,
  output logic [15:0]                frame_seq,
  output logic [2:0]                 err_code,
  output logic [15:0]                stat_good,
  output logic [15:0]                stat_bad
);

  logic [1:0]                 dibit_q, dibit_d;
  logic                       crs_q, crs_d;
  state_e                     state_q, state_d;
  logic [7:0]                 pre_cnt_q, pre_cnt_d;
  logic [3:0]                 dib_cnt_q, dib_cnt_d;
  logic [1:0]                 hdr_cnt_q, hdr_cnt_d;
  logic [31:0]                word_q, word_d;
  logic [31:0]                held_q, held_d;
  logic                       held_vld_q, held_vld_d;
  logic [MAC_PACKET_BITS-1:0] wr_cnt_q, wr_cnt_d;
  logic                       dst_ok_q, dst_ok_d;
  logic [15:0]                seq_q, seq_d;
  logic [2:0]                 err_pend_q, err_pend_d;
  logic [31:0]                data_q, data_d;
  logic                       wr_en_q, wr_en_d;
  logic                       commit_q, commit_d;
  logic                       discard_q, discard_d;
  logic [MAC_PACKET_BITS-1:0] len_q, len_d;
  logic [15:0]                fseq_q, fseq_d;
  logic [2:0]                 err_q, err_d;

  logic [4:0]                 bit_idx;
  logic [31:0]                word_nx;
  logic                       crc_init;
  logic                       crc_en;
  logic                       crc_match;
  logic [31:0]                crc_val_unused;

  // The CRC runs only while frame bytes are arriving; it is re-armed otherwise
  // so the first dibit after the SFD sees the initial value.
  assign crc_init = (state_q != ST_HEADER) && (state_q != ST_PAYLOAD);
  assign crc_en   = crs_q && !crc_init;

  mac_rx_crc32 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .dibit (dibit_q),
    .crc   (crc_val_unused),
    .match (crc_match)
  );

  // Input capture: every decision below works on these registered values.
  always_comb begin
    dibit_d = {rx1, rx0};
    crs_d   = crs_dv;
  end

  // Receive FSM: next state, word assembly, filtering and output pulses.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    dib_cnt_d  = dib_cnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    word_d     = word_q;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    wr_cnt_d   = wr_cnt_q;
    dst_ok_d   = dst_ok_q;
    seq_d      = seq_q;
    err_pend_d = err_pend_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    commit_d   = 1'b0;
    discard_d  = 1'b0;
    len_d      = len_q;
    fseq_d     = fseq_q;
    err_d      = err_q;

    // Byte b of the word lands in [31-8b -: 8]; dibit d of a byte is bits 2d+1:2d.
    bit_idx = {~dib_cnt_q[3:2], dib_cnt_q[1:0], 1'b0};
    word_nx = word_q;
    word_nx[bit_idx +: 2] = dibit_q;

    case (state_q)
      ST_IDLE: begin
        if (crs_q && dibit_q == DIBIT_PRE) begin
          state_d   = ST_PREAMBLE;
          pre_cnt_d = 8'd1;
        end
      end

      ST_PREAMBLE: begin
        if (!crs_q) begin
          state_d = ST_IDLE;
        end else if (dibit_q == DIBIT_PRE) begin
          if (pre_cnt_q != 8'hff) pre_cnt_d = pre_cnt_q + 8'd1;
        end else if (dibit_q == DIBIT_SFD && pre_cnt_q >= 8'(MIN_PREAMBLE)) begin
          state_d   = ST_HEADER;
          dib_cnt_d = 4'd0;
          hdr_cnt_d = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HEADER: begin
        if (!crs_q) begin
          // Carrier lost inside the header: the frame is too short to keep.
          state_d   = ST_IDLE;
          discard_d = 1'b1;
          err_d     = ERR_RUNT;
        end else begin
          word_d    = word_nx;
          dib_cnt_d = dib_cnt_q + 4'd1;
          if (hdr_cnt_q == 2'd1 && dib_cnt_q == 4'd7 &&
              !(dst_ok_q && word_nx[31:16] == local_mac[15:0])) begin
            state_d    = ST_DROP;
            err_pend_d = ERR_DST;
          end else if (dib_cnt_q == 4'd15) begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd0) dst_ok_d = (word_nx == local_mac[47:16]);
            if (hdr_cnt_q == 2'd3) begin
              if (word_nx[31:16] != ETHER_MAGIC) begin
                state_d    = ST_DROP;
                err_pend_d = ERR_MAGIC;
              end else begin
                state_d    = ST_PAYLOAD;
                seq_d      = word_nx[15:0];
                held_vld_d = 1'b0;
                wr_cnt_d   = '0;
              end
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (!crs_q) begin
          state_d = ST_IDLE;
          if (dib_cnt_q != 4'd0) begin
            discard_d = 1'b1;
            err_d     = ERR_ALIGN;
          end else if (wr_cnt_q == '0) begin
            discard_d = 1'b1;
            err_d     = ERR_RUNT;
          end else if (!crc_match) begin
            discard_d = 1'b1;
            err_d     = ERR_CRC;
          end else begin
            commit_d = 1'b1;
            len_d    = wr_cnt_q;
            fseq_d   = seq_q;
          end
        end else begin
          word_d    = word_nx;
          dib_cnt_d = dib_cnt_q + 4'd1;
          if (dib_cnt_q == 4'd15) begin
            // The word just completed is held back; the previously held one
            // is now known not to be the FCS and can be written.
            held_d     = word_nx;
            held_vld_d = 1'b1;
            if (held_vld_q) begin
              if (wr_cnt_q == MAC_PACKET_BITS'(MAX_WORDS)) begin
                state_d    = ST_DROP;
                err_pend_d = ERR_OVF;
              end else if (data_full) begin
                state_d    = ST_DROP;
                err_pend_d = ERR_FULL;
              end else begin
                data_d   = held_q;
                wr_en_d  = 1'b1;
                wr_cnt_d = wr_cnt_q + MAC_PACKET_BITS'(1);
              end
            end
          end
        end
      end

      ST_DROP: begin
        if (!crs_q) begin
          state_d   = ST_IDLE;
          discard_d = 1'b1;
          err_d     = err_pend_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dibit_q    <= 2'b00;
      crs_q      <= 1'b0;
      state_q    <= ST_IDLE;
      pre_cnt_q  <= 8'd0;
      dib_cnt_q  <= 4'd0;
      hdr_cnt_q  <= 2'd0;
      word_q     <= 32'd0;
      held_q     <= 32'd0;
      held_vld_q <= 1'b0;
      wr_cnt_q   <= '0;
      dst_ok_q   <= 1'b0;
      seq_q      <= 16'd0;
      err_pend_q <= ERR_NONE;
      data_q     <= 32'd0;
      wr_en_q    <= 1'b0;
      commit_q   <= 1'b0;
      discard_q  <= 1'b0;
      len_q      <= '0;
      fseq_q     <= 16'd0;
      err_q      <= ERR_NONE;
    end else begin
      dibit_q    <= dibit_d;
      crs_q      <= crs_d;
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      dib_cnt_q  <= dib_cnt_d;
      hdr_cnt_q  <= hdr_cnt_d;
      word_q     <= word_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      wr_cnt_q   <= wr_cnt_d;
      dst_ok_q   <= dst_ok_d;
      seq_q      <= seq_d;
      err_pend_q <= err_pend_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
      commit_q   <= commit_d;
      discard_q  <= discard_d;
      len_q      <= len_d;
      fseq_q     <= fseq_d;
      err_q      <= err_d;
    end
  end

  assign data_out      = data_q;
  assign data_wr_en    = wr_en_q;
  assign frame_commit  = commit_q;
  assign frame_discard = discard_q;
  assign frame_len     = len_q;
  assign frame_seq     = fseq_q;
  assign err_code      = err_q;

`ifdef MAC_RX_STATS_EN
  logic [15:0] stat_good_q, stat_good_d;
  logic [15:0] stat_bad_q, stat_bad_d;

  // Saturating frame counters, stepping together with the commit/discard pulse.
  always_comb begin
    stat_good_d = stat_good_q;
    stat_bad_d  = stat_bad_q;
    if (commit_d && stat_good_q != 16'hffff)  stat_good_d = stat_good_q + 16'd1;
    if (discard_d && stat_bad_q != 16'hffff)  stat_bad_d  = stat_bad_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good_q <= 16'd0;
      stat_bad_q  <= 16'd0;
    end else begin
      stat_good_q <= stat_good_d;
      stat_bad_q  <= stat_bad_d;
    end
  end

  assign stat_good = stat_good_q;
  assign stat_bad  = stat_bad_q;
`else
  assign stat_good = 16'd0;
  assign stat_bad  = 16'd0;
`endif

endmodule
